// File: rtl/serial_regfile_pkg.sv
// Shared types and default sizing for the digit-serial register file.
package serial_regfile_pkg;

  localparam int unsigned DefXlen  = 32;
  localparam int unsigned DefDigit = 2;
  localparam int unsigned DefNregs = 16;

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

endpackage

// File: rtl/serial_seq.sv
// Pass sequencer: IDLE/SHIFT FSM, digit counter, busy/done and the per-cycle step enable.
module serial_seq
  import serial_regfile_pkg::*;
#(
  parameter int unsigned NDIGITS = DefXlen / DefDigit,
  parameter int unsigned IdxW    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            hold,
  output logic            busy,
  output logic            done,
  output logic            step,
  output logic            accept,
  output logic [IdxW-1:0] digit_idx
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NDIGITS - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // hold freezes everything, including acceptance of a new pass
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !hold) state_d = StShift;
      end
      StShift: begin
        if (!hold) begin
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q == StShift);
    step      = busy && !hold;
    accept    = (state_q == StIdle) && start && !hold;
    done      = done_q;
    digit_idx = busy ? idx_q : '0;
  end

endmodule

// File: rtl/serial_regfile.sv
// Digit-serial register file: every register rotates right by DIGIT bits per shift cycle.
// Optional parallel access port enabled by defining SERIAL_REGFILE_PAR_EN.
module serial_regfile
  import serial_regfile_pkg::*;
#(
  parameter int unsigned XLEN  = DefXlen,
  parameter int unsigned DIGIT = DefDigit,
  parameter int unsigned NREGS = DefNregs,
  localparam int unsigned SelW    = $clog2(NREGS),
  localparam int unsigned NDIGITS = XLEN / DIGIT,
  localparam int unsigned IdxW    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  input  logic [SelW-1:0]  rs1,
  input  logic [SelW-1:0]  rs2,
  input  logic [SelW-1:0]  rd,
  input  logic             wr_en,
  input  logic [DIGIT-1:0] wr_digit,
  output logic [DIGIT-1:0] rd_digit1,
  output logic [DIGIT-1:0] rd_digit2,
  output logic             busy,
  output logic             done,
  output logic [IdxW-1:0]  digit_idx
`ifdef SERIAL_REGFILE_PAR_EN
  ,
  input  logic [SelW-1:0]  par_sel,
  input  logic             par_we,
  input  logic [XLEN-1:0]  par_wdata,
  output logic [XLEN-1:0]  par_rdata
`endif
);

  if ((XLEN % DIGIT) != 0 || (DIGIT != 1 && DIGIT != 2 && DIGIT != 4 && DIGIT != 8))
  begin : g_bad_digit
    $error("serial_regfile: DIGIT must be 1/2/4/8 and divide XLEN");
  end
  if (NREGS < 2 || NREGS > 32 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
    $error("serial_regfile: NREGS must be a power of two in 2..32");
  end

  logic            step, accept;
  logic [SelW-1:0] rs1_q, rs2_q, rd_q;
  logic            wr_en_q;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  serial_seq #(
    .NDIGITS (NDIGITS),
    .IdxW    (IdxW)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hold      (hold),
    .busy      (busy),
    .done      (done),
    .step      (step),
    .accept    (accept),
    .digit_idx (digit_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wr_en_q <= 1'b0;
    end else if (accept) begin
      rs1_q   <= rs1;
      rs2_q   <= rs2;
      rd_q    <= rd;
      wr_en_q <= wr_en;
    end
  end

  // x0 is never loaded, so it stays at its reset value of zero
  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    regs_d[0] = '0;
    if (step) begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr_en_q && rd_q == SelW'(i)) begin
          regs_d[i] = {wr_digit, regs_q[i][XLEN-1:DIGIT]};
        end else begin
          regs_d[i] = {regs_q[i][DIGIT-1:0], regs_q[i][XLEN-1:DIGIT]};
        end
      end
    end
`ifdef SERIAL_REGFILE_PAR_EN
    if (!busy && !hold && par_we && par_sel != '0) regs_d[par_sel] = par_wdata;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    rd_digit1 = busy ? regs_q[rs1_q][DIGIT-1:0] : '0;
    rd_digit2 = busy ? regs_q[rs2_q][DIGIT-1:0] : '0;
  end

`ifdef SERIAL_REGFILE_PAR_EN
  assign par_rdata = regs_q[par_sel];
`endif

endmodule

// File: tb/tb_serial_regfile.sv
// Self-checking bench for serial_regfile: directed table, hand sequences and randomized passes.
module tb_serial_regfile;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, hold, wr_en;
  logic [3:0] rs1, rs2, rd;
  logic [1:0] wr_digit, rd_digit1, rd_digit2;
  logic       busy, done;
  logic [3:0] digit_idx;

  logic       start_b, hold_b, wr_en_b;
  logic [2:0] rs1_b, rs2_b, rd_b;
  logic [3:0] wr_digit_b, rd_digit1_b, rd_digit2_b;
  logic       busy_b, done_b;
  logic [1:0] digit_idx_b;

  always #5 clk = ~clk;

  serial_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hold      (hold),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .wr_en     (wr_en),
    .wr_digit  (wr_digit),
    .rd_digit1 (rd_digit1),
    .rd_digit2 (rd_digit2),
    .busy      (busy),
    .done      (done),
    .digit_idx (digit_idx)
  );

  serial_regfile #(
    .XLEN  (16),
    .DIGIT (4),
    .NREGS (8)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .start     (start_b),
    .hold      (hold_b),
    .rs1       (rs1_b),
    .rs2       (rs2_b),
    .rd        (rd_b),
    .wr_en     (wr_en_b),
    .wr_digit  (wr_digit_b),
    .rd_digit1 (rd_digit1_b),
    .rd_digit2 (rd_digit2_b),
    .busy      (busy_b),
    .done      (done_b),
    .digit_idx (digit_idx_b)
  );

  int nvec  = 0;
  int nfail = 0;

  // Architectural view of the register file: whole values, no rotation state.
  logic [31:0] model [16];

  typedef struct {
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp1;
    int          hold_at;
    int          hold_len;
    int          spur_at;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_pass(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                          input logic we, input logic [31:0] wdata, input logic [31:0] exp1,
                          input int hold_at, input int hold_len, input int spur_at);
    logic [31:0] exp2;
    int k, held, cycles, want;
    exp2  = model[b];
    rs1   = a;
    rs2   = b;
    rd    = d;
    wr_en = we;
    start = 1'b1;
    hold  = 1'b0;
    wr_digit = 2'd0;
    @(negedge clk);
    start = 1'b0;
    rs1   = ~a;
    rs2   = ~b;
    rd    = ~d;
    wr_en = ~we;
    check("done_low_first_busy_cycle", 32'(done), 32'd0);
    k = 0;
    held = 0;
    cycles = 0;
    while (k < N && cycles < 4 * N) begin
      check("busy_in_pass", 32'(busy), 32'd1);
      check("digit_idx", 32'(digit_idx), 32'(k));
      check("rd_digit1", 32'(rd_digit1), (exp1 >> (2 * k)) & 32'd3);
      check("rd_digit2", 32'(rd_digit2), (exp2 >> (2 * k)) & 32'd3);
      hold     = (k == hold_at && held < hold_len);
      start    = (k == spur_at);
      wr_digit = wdata[2*k +: 2];
      @(negedge clk);
      if (hold) held++;
      else k++;
      cycles++;
    end
    hold  = 1'b0;
    start = 1'b0;
    want  = N + ((hold_at >= 0) ? hold_len : 0);
    check("pass_cycles", 32'(cycles), 32'(want));
    check("done_pulse", 32'(done), 32'd1);
    check("busy_low_at_done", 32'(busy), 32'd0);
    check("digit_idx_wrapped", 32'(digit_idx), 32'd0);
    if (we && d != 4'd0) model[d] = wdata;
  endtask

  initial begin
    logic [15:0] wb;
    rst = 1'b1;
    start = 1'b0; hold = 1'b0; wr_en = 1'b0; wr_digit = '0;
    rs1 = '0; rs2 = '0; rd = '0;
    start_b = 1'b0; hold_b = 1'b0; wr_en_b = 1'b0; wr_digit_b = '0;
    rs1_b = '0; rs2_b = '0; rd_b = '0;
    for (int i = 0; i < 16; i++) model[i] = 32'd0;

    tbl[0] = '{4'd0, 4'd0, 4'd5, 1'b1, 32'hDEADBEEF, 32'h0,        -1, 0, -1};
    tbl[1] = '{4'd5, 4'd0, 4'd0, 1'b0, 32'h0,        32'hDEADBEEF, -1, 0, -1};
    tbl[2] = '{4'd1, 4'd5, 4'd0, 1'b1, 32'hFFFFFFFF, 32'h0,        -1, 0, -1};
    tbl[3] = '{4'd0, 4'd5, 4'd2, 1'b0, 32'h0,        32'h0,        -1, 0, -1};
    tbl[4] = '{4'd0, 4'd0, 4'd7, 1'b1, 32'h12345678, 32'h0,        -1, 0, -1};
    tbl[5] = '{4'd7, 4'd5, 4'd7, 1'b1, 32'hCAFEF00D, 32'h12345678, -1, 0, -1};
    tbl[6] = '{4'd7, 4'd5, 4'd0, 1'b0, 32'h0,        32'hCAFEF00D,  8, 3, -1};
    tbl[7] = '{4'd5, 4'd7, 4'd0, 1'b0, 32'h0,        32'hDEADBEEF, -1, 0,  3};

    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_digit_idx", 32'(digit_idx), 32'd0);
    check("reset_rd_digit1", 32'(rd_digit1), 32'd0);
    check("reset_rd_digit2", 32'(rd_digit2), 32'd0);
    rst = 1'b0;

    // Back-to-back: each pass starts in the done cycle of the previous one.
    for (int i = 0; i < 8; i++) begin
      run_pass(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].we, tbl[i].wdata, tbl[i].exp1,
               tbl[i].hold_at, tbl[i].hold_len, tbl[i].spur_at);
    end

    // Reset in the middle of a writing pass.
    @(negedge clk);
    rs1 = 4'd5; rs2 = 4'd7; rd = 4'd9; wr_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) begin
      wr_digit = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    check("pre_reset_digit_idx", 32'(digit_idx), 32'd8);
    rst = 1'b1;
    #1;
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_done", 32'(done), 32'd0);
    check("async_reset_digit_idx", 32'(digit_idx), 32'd0);
    check("async_reset_rd_digit1", 32'(rd_digit1), 32'd0);
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    run_pass(4'd5, 4'd7, 4'd9, 1'b0, 32'h0, 32'h0, -1, 0, -1);
    run_pass(4'd9, 4'd0, 4'd0, 1'b0, 32'h0, 32'h0, -1, 0, -1);

    for (int i = 0; i < 24; i++) begin
      logic [3:0] a, b, d;
      logic [31:0] w;
      int ha;
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      d  = 4'($urandom_range(0, 15));
      w  = $urandom;
      ha = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        check("idle_rd_digit1", 32'(rd_digit1), 32'd0);
        check("idle_done_cleared", 32'(done), 32'd0);
      end
      run_pass(a, b, d, 1'($urandom_range(0, 1)), w, model[a], ha,
               int'($urandom_range(1, 3)), -1);
    end

    // Narrow configuration: 16-bit registers, 4-bit digits, 8 registers.
    wb = 16'hA5C3;
    @(negedge clk);
    rd_b = 3'd3; wr_en_b = 1'b1; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("b_busy", 32'(busy_b), 32'd1);
      check("b_digit_idx", 32'(digit_idx_b), 32'(k));
      wr_digit_b = wb[4*k +: 4];
      @(negedge clk);
    end
    check("b_done_after_4", 32'(done_b), 32'd1);
    rs1_b = 3'd3; rd_b = 3'd0; wr_en_b = 1'b0; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("b_rd_digit1", 32'(rd_digit1_b), 32'(wb[4*k +: 4]));
      @(negedge clk);
    end
    check("b_read_done", 32'(done_b), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/serial_regfile.md
SERIAL_REGFILE -- requirements
Module: serial_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, register width in bits.
REQ-002 SHALL have parameter DIGIT, default 2, bits moved per cycle; XLEN % DIGIT == 0 and DIGIT in {1,2,4,8}, else elaboration error.
REQ-003 SHALL have parameter NREGS, default 16, register count; power of two, 2..32.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request one serial pass.
REQ-007 SHALL have port hold  input  1  stall the current pass for this cycle.
REQ-008 SHALL have ports rs1, rs2, rd  input  $clog2(NREGS) each  read/write selects, sampled on accepted start.
REQ-009 SHALL have port wr_en  input  1  write rd during this pass, sampled on accepted start.
REQ-010 SHALL have port wr_digit  input  DIGIT  next digit for rd, LSB-first order.
REQ-011 SHALL have ports rd_digit1, rd_digit2  output  DIGIT each  current low digit of latched rs1 / rs2.
REQ-012 SHALL have ports busy, done  output  1 each  pass active / one-cycle completion pulse.
REQ-013 SHALL have port digit_idx  output  $clog2(XLEN/DIGIT)  index of digit presented this cycle.

Function
REQ-014 SHALL implement FSM IDLE -> SHIFT -> IDLE; SHIFT lasts exactly N = XLEN/DIGIT non-held cycles.
REQ-015 SHALL accept start only in IDLE; start in SHIFT SHALL be ignored, no queuing.
REQ-016 SHALL latch rs1, rs2, rd, wr_en on the accepting edge; busy SHALL rise the next cycle.
REQ-017 SHALL, on each non-held SHIFT cycle, rotate every register except x0 right by DIGIT bits (low digit to top).
REQ-018 SHALL, when latched wr_en=1 and rd!=0, replace rd's top digit with wr_digit in the same update, i.e. rd <= {wr_digit, rd[XLEN-1:DIGIT]}.
REQ-019 SHALL present rd_digit1/2 combinationally from registers before the edge's update; rs==rd SHALL return the old digit.
REQ-020 SHALL keep x0 at zero; reads of x0 return 0 and writes to x0 are dropped.
REQ-021 SHALL drive rd_digit1/2 to 0 and digit_idx to 0 while in IDLE.
REQ-022 SHALL, with hold=1, freeze registers, digit_idx and state; outputs keep last values.
REQ-023 SHALL increment digit_idx per non-held SHIFT cycle, wrapping N-1 -> 0 on exit.
REQ-024 SHALL pulse done for exactly one cycle, the cycle after the edge that processed digit N-1, with busy=0 in that cycle; start in that cycle is accepted.
REQ-025 SHALL leave every register rotated back to original alignment after a full pass (net rotation XLEN).

Reset
REQ-026 SHALL, on rst assertion, immediately clear all registers, state to IDLE, digit_idx=0, busy=0, done=0, latched selects and wr_en=0.
REQ-027 SHALL abort a pass in progress on rst with no partial-write preservation; first start is accepted on the first edge after rst deasserts.

Configuration
REQ-028 SHALL, when SERIAL_REGFILE_PAR_EN is defined, add ports par_sel ($clog2(NREGS)) in, par_we in, par_wdata (XLEN) in, par_rdata (XLEN) out.
REQ-029 SHALL, with SERIAL_REGFILE_PAR_EN, perform par_we writes only in IDLE (ignored in SHIFT, x0 ignored); par_rdata combinational, 0 for x0.
REQ-030 SHALL, without SERIAL_REGFILE_PAR_EN, omit those ports and logic entirely.

Structure
REQ-031 SHALL place the state enum (IDLE, SHIFT) and default XLEN/DIGIT/NREGS constants in package serial_regfile_pkg.
REQ-032 SHALL factor the FSM plus digit counter into sub-module serial_seq (outputs busy, done, digit_idx, step enable).

Verification
REQ-033 SHALL test: defaults, write x5 over a pass with wr_digit sequence of 0xDEADBEEF LSB-first -> next pass rd_digit1 (rs1=5) yields 0xDEADBEEF LSB-first, done after 16 shift cycles.
REQ-034 SHALL test: rd=0, wr_en=1, wr_digit=3 all pass -> rs1=0 reads all-zero digits next pass.
REQ-035 SHALL test: rs1=rd=7 holding 0x12345678, write 0xCAFEF00D -> rd_digit1 streams 0x12345678 this pass, 0xCAFEF00D next pass.
REQ-036 SHALL test: hold=1 for 3 cycles mid-pass -> done arrives 19 cycles after busy rises, data intact.
REQ-037 SHALL test: rst asserted at digit_idx=8 -> busy/done/registers immediately 0; start ignored while busy then accepted the cycle of done.
REQ-038 SHALL test: XLEN=16, DIGIT=4, NREGS=8 -> done after 4 cycles, round-trip write/read of 0xA5C3.
